// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns a command byte plus a 16-bit word into a register write or read.
// Optional macro AUTO_INC_EN: further word pairs in the same frame write to incrementing addresses.
module spi_cmd_ctrl #(
    parameter int         ADDR_W         = 7,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] STATUS_BYTE    = 8'hA5
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    input  logic              i_spi_ss,
    input  logic [15:0]       i_rd_data,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_wr_data,
    output logic [7:0]        o_tx_byte,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_HI  = 3'd1;
    localparam logic [2:0] WR_LO  = 3'd2;
    localparam logic [2:0] RD_LAT = 3'd3;
    localparam logic [2:0] RD_HI  = 3'd4;
    localparam logic [2:0] RD_LO  = 3'd5;

    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [7:0]    rd_lo;
    logic          ss_prev;
    logic          ss_rise;
    logic          byte_ok;
    logic          timed_out;
    logic          boundary;

`ifdef AUTO_INC_EN
    logic burst;
    assign boundary = (state == WR_HI) && burst;
`else
    logic drain;
    assign boundary = 1'b0;
`endif

    assign ss_rise   = i_spi_ss && !ss_prev;
    assign byte_ok   = i_byte_valid && !i_spi_ss;
    assign timed_out = (timer == T_LAST);
    assign o_busy    = (state != IDLE);

    // Inter-byte watchdog; idle and the read-latency cycle never count toward an abort.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            timer   <= '0;
            ss_prev <= 1'b1;
        end else begin
            ss_prev <= i_spi_ss;
            if (i_byte_valid || state == IDLE || state == RD_LAT || timed_out)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            rd_lo     <= '0;
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_tx_byte <= STATUS_BYTE;
            o_err     <= 1'b0;
`ifdef AUTO_INC_EN
            burst     <= 1'b0;
`else
            drain     <= 1'b0;
`endif
        end else begin
            o_wr_en <= 1'b0;
            o_rd_en <= 1'b0;
`ifdef AUTO_INC_EN
            // Step the address once the previous word's strobe has been seen.
            if (o_wr_en && state == WR_HI)
                o_addr <= o_addr + 1'b1;
`else
            if (i_spi_ss)
                drain <= 1'b0;
`endif
            if (state != IDLE && ss_rise) begin
                state     <= IDLE;
                o_tx_byte <= STATUS_BYTE;
                if (!boundary)
                    o_err <= 1'b1;
`ifdef AUTO_INC_EN
                burst <= 1'b0;
`endif
            end else if (state != IDLE && state != RD_LAT && !i_byte_valid && timed_out) begin
                state     <= IDLE;
                o_tx_byte <= STATUS_BYTE;
                o_err     <= 1'b1;
`ifdef AUTO_INC_EN
                burst <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_ok) begin
`ifndef AUTO_INC_EN
                            if (drain) begin
                                o_err <= 1'b1;
                            end else begin
`else
                            begin
                                burst <= 1'b0;
`endif
                                o_addr <= i_byte[ADDR_W-1:0];
                                o_err  <= 1'b0;
                                if (i_byte[7]) begin
                                    state <= WR_HI;
                                end else begin
                                    o_rd_en <= 1'b1;
                                    state   <= RD_LAT;
                                end
                            end
                        end
                    end
                    WR_HI: begin
                        if (byte_ok) begin
                            o_wr_data[15:8] <= i_byte;
                            state           <= WR_LO;
                        end
                    end
                    WR_LO: begin
                        if (byte_ok) begin
                            o_wr_data[7:0] <= i_byte;
                            o_wr_en        <= 1'b1;
`ifdef AUTO_INC_EN
                            state <= WR_HI;
                            burst <= 1'b1;
`else
                            state <= IDLE;
                            drain <= 1'b1;
`endif
                        end
                    end
                    RD_LAT: begin
                        o_tx_byte <= i_rd_data[15:8];
                        rd_lo     <= i_rd_data[7:0];
                        state     <= RD_HI;
                    end
                    RD_HI: begin
                        if (byte_ok) begin
                            o_tx_byte <= rd_lo;
                            state     <= RD_LO;
                        end
                    end
                    RD_LO: begin
                        if (byte_ok) begin
                            o_tx_byte <= STATUS_BYTE;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl; expectations follow AUTO_INC_EN when it is defined.
module tb_spi_cmd_ctrl;

    localparam int TMO = 40;

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        i_sys_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic        i_spi_ss = 1'b1;
    logic [15:0] i_rd_data;
    logic        o_wr_en;
    logic        o_rd_en;
    logic [6:0]  o_addr;
    logic [15:0] o_wr_data;
    logic [7:0]  o_tx_byte;
    logic        o_busy;
    logic        o_err;

    logic [15:0] mem [0:127];
    txn_t        sb[$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cycle = 0;
    int          strobeCycle = 0;
    logic        prevWr = 1'b0;
    logic        prevRd = 1'b0;

    spi_cmd_ctrl #(
        .ADDR_W(7),
        .TIMEOUT_CYCLES(TMO),
        .STATUS_BYTE(8'hA5)
    ) dut (
        .i_sys_clk(i_sys_clk),
        .i_rst(i_rst),
        .i_byte(i_byte),
        .i_byte_valid(i_byte_valid),
        .i_spi_ss(i_spi_ss),
        .i_rd_data(i_rd_data),
        .o_wr_en(o_wr_en),
        .o_rd_en(o_rd_en),
        .o_addr(o_addr),
        .o_wr_data(o_wr_data),
        .o_tx_byte(o_tx_byte),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    // Register file model: read data simply follows the presented address.
    assign i_rd_data = mem[o_addr];

    always @(posedge i_sys_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge i_sys_clk);
        #1;
        i_byte       = b;
        i_byte_valid = 1'b1;
        strobeCycle  = cycle;
        @(posedge i_sys_clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge i_sys_clk);
        #1;
    endtask

    task automatic setSs(input logic v);
        @(posedge i_sys_clk);
        #1;
        i_spi_ss = v;
    endtask

    // Strobe monitor: every strobe must match the oldest expected transaction.
    always @(negedge i_sys_clk) begin
        if (o_wr_en && o_rd_en)
            checkOutput("strobe_overlap", 32'd1, 32'd0);
        if (o_wr_en && prevWr)
            checkOutput("wr_width", 32'd2, 32'd1);
        if (o_rd_en && prevRd)
            checkOutput("rd_width", 32'd2, 32'd1);
        if ((o_wr_en && !prevWr) || (o_rd_en && !prevRd)) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                txn_t t;
                t = sb.pop_front();
                checkOutput("strobe_kind", {31'd0, o_wr_en}, {31'd0, t.wr});
                checkOutput("strobe_addr", {25'd0, o_addr}, {25'd0, t.addr});
                checkOutput("strobe_latency", cycle - strobeCycle, 32'd1);
                if (t.wr)
                    checkOutput("wr_data", {16'd0, o_wr_data}, {16'd0, t.data});
            end
        end
        prevWr <= o_wr_en;
        prevRd <= o_rd_en;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[5] = 16'hBEEF;

        i_rst = 1'b1;
        repeat (3) @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        checkOutput("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        checkOutput("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
        checkOutput("rst_addr", {25'd0, o_addr}, 32'd0);
        checkOutput("rst_wr_data", {16'd0, o_wr_data}, 32'd0);
        checkOutput("rst_tx_byte", {24'd0, o_tx_byte}, 32'hA5);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_err", {31'd0, o_err}, 32'd0);
        @(posedge i_sys_clk);
        #1;
        i_rst = 1'b0;

        $display("[TB] write 0x18 = 0x1234");
        setSs(1'b0);
        sb.push_back('{1'b1, 7'h18, 16'h1234});
        applyStimulus(8'h98);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        idleCycles(2);
        setSs(1'b1);
        idleCycles(2);
        @(negedge i_sys_clk);
        checkOutput("wr_err", {31'd0, o_err}, 32'd0);
        checkOutput("wr_busy", {31'd0, o_busy}, 32'd0);

        $display("[TB] read 0x05");
        setSs(1'b0);
        sb.push_back('{1'b0, 7'h05, 16'h0000});
        applyStimulus(8'h05);
        @(negedge i_sys_clk);
        @(negedge i_sys_clk);
        checkOutput("rd_tx_hi", {24'd0, o_tx_byte}, 32'hBE);
        checkOutput("rd_busy", {31'd0, o_busy}, 32'd1);
        applyStimulus(8'h00);
        @(negedge i_sys_clk);
        checkOutput("rd_tx_lo", {24'd0, o_tx_byte}, 32'hEF);
        applyStimulus(8'h00);
        @(negedge i_sys_clk);
        checkOutput("rd_tx_status", {24'd0, o_tx_byte}, 32'hA5);
        checkOutput("rd_done_busy", {31'd0, o_busy}, 32'd0);
        setSs(1'b1);
        idleCycles(2);

        $display("[TB] abort on ss deassert mid-word");
        setSs(1'b0);
        applyStimulus(8'h98);
        applyStimulus(8'h12);
        setSs(1'b1);
        idleCycles(1);
        @(negedge i_sys_clk);
        checkOutput("abort_err", {31'd0, o_err}, 32'd1);
        checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("abort_tx", {24'd0, o_tx_byte}, 32'hA5);

        $display("[TB] next command clears error");
        setSs(1'b0);
        sb.push_back('{1'b1, 7'h03, 16'h1122});
        applyStimulus(8'h83);
        @(negedge i_sys_clk);
        checkOutput("err_cleared", {31'd0, o_err}, 32'd0);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        idleCycles(1);
        setSs(1'b1);
        idleCycles(2);

        $display("[TB] byte coincident with ss deassert is discarded");
        setSs(1'b0);
        applyStimulus(8'h98);
        applyStimulus(8'h12);
        @(posedge i_sys_clk);
        #1;
        i_byte       = 8'h34;
        i_byte_valid = 1'b1;
        i_spi_ss     = 1'b1;
        @(posedge i_sys_clk);
        #1;
        i_byte_valid = 1'b0;
        idleCycles(1);
        @(negedge i_sys_clk);
        checkOutput("race_err", {31'd0, o_err}, 32'd1);
        checkOutput("race_busy", {31'd0, o_busy}, 32'd0);

        $display("[TB] inter-byte timeout");
        setSs(1'b0);
        applyStimulus(8'h98);
        n = 0;
        do begin
            @(negedge i_sys_clk);
            n++;
        end while (o_busy && n < TMO + 20);
        checkOutput("tmo_latency", n, TMO + 1);
        checkOutput("tmo_err", {31'd0, o_err}, 32'd1);
        setSs(1'b1);
        idleCycles(2);

        $display("[TB] byte on the timeout cycle wins");
        setSs(1'b0);
        sb.push_back('{1'b1, 7'h18, 16'h5678});
        applyStimulus(8'h98);
        repeat (TMO - 2) @(posedge i_sys_clk);
        applyStimulus(8'h56);
        @(negedge i_sys_clk);
        checkOutput("tmo_race_busy", {31'd0, o_busy}, 32'd1);
        checkOutput("tmo_race_err", {31'd0, o_err}, 32'd0);
        applyStimulus(8'h78);
        idleCycles(1);
        setSs(1'b1);
        idleCycles(2);

        $display("[TB] byte with ss high is ignored");
        applyStimulus(8'h98);
        @(negedge i_sys_clk);
        checkOutput("ign_busy", {31'd0, o_busy}, 32'd0);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        @(negedge i_sys_clk);
        checkOutput("ign_busy2", {31'd0, o_busy}, 32'd0);

        $display("[TB] reset mid-frame");
        setSs(1'b0);
        applyStimulus(8'h98);
        applyStimulus(8'h12);
        i_rst = 1'b1;
        @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        checkOutput("midrst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("midrst_wr_data", {16'd0, o_wr_data}, 32'd0);
        checkOutput("midrst_addr", {25'd0, o_addr}, 32'd0);
        @(posedge i_sys_clk);
        #1;
        i_rst = 1'b0;
        setSs(1'b1);
        idleCycles(2);

        $display("[TB] multi-word stream 0xFF 00 01 00 02");
        setSs(1'b0);
        sb.push_back('{1'b1, 7'h7F, 16'h0001});
`ifdef AUTO_INC_EN
        sb.push_back('{1'b1, 7'h00, 16'h0002});
`endif
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        idleCycles(1);
        setSs(1'b1);
        idleCycles(2);
        @(negedge i_sys_clk);
`ifdef AUTO_INC_EN
        checkOutput("stream_err", {31'd0, o_err}, 32'd0);
`else
        checkOutput("stream_err", {31'd0, o_err}, 32'd1);
`endif
        checkOutput("stream_busy", {31'd0, o_busy}, 32'd0);

        idleCycles(4);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
